// File: rtl/hack_run_controller.sv
// Run/debug controller for a Hack CPU: decodes a byte command stream into ROM loads,
// run/halt/step control, a single PC breakpoint and CPU reset requests.
module hack_run_controller #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    input  logic [7:0]            cmd_data,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  cpu_hold,
    output logic                  cpu_reset,
    output logic                  rom_write,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic [15:0]           rom_data,
    output logic                  running,
    output logic                  cmd_error
);

    localparam int HI_W = ADDR_WIDTH - 8;

    localparam logic [7:0] OP_LOAD   = 8'h4C;
    localparam logic [7:0] OP_RUN    = 8'h52;
    localparam logic [7:0] OP_HALT   = 8'h48;
    localparam logic [7:0] OP_STEP   = 8'h53;
    localparam logic [7:0] OP_BP_SET = 8'h42;
    localparam logic [7:0] OP_BP_CLR = 8'h43;
    localparam logic [7:0] OP_CPURST = 8'h5A;

    typedef enum logic [3:0] {
        ST_CPURST    = 4'd0,
        ST_HALTED    = 4'd1,
        ST_RUN       = 4'd2,
        ST_STEP      = 4'd3,
        ST_LD_CNT_HI = 4'd4,
        ST_LD_CNT_LO = 4'd5,
        ST_LD_HI     = 4'd6,
        ST_LD_LO     = 4'd7,
        ST_BP_HI     = 4'd8,
        ST_BP_LO     = 4'd9
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    state_t                  cmd_next_s;
    logic                    accept_s;
    logic                    cmd_state_s;
    logic                    bp_match_s;

    logic [7:0]              byte_hi_r;
    logic [15:0]             words_left_r;
    logic [ADDR_WIDTH-1:0]   ld_addr_r;
    logic [ADDR_WIDTH-1:0]   bp_addr_r;
    logic                    bp_enable_r;
    logic                    bp_armed_r;

    logic                    cmd_ready_r;
    logic                    cpu_reset_r;
    logic                    rom_write_r;
    logic [ADDR_WIDTH-1:0]   rom_address_r;
    logic [15:0]             rom_data_r;
    logic                    cmd_error_r;

    function automatic logic is_opcode(input logic [7:0] b);
        case (b)
            OP_LOAD, OP_RUN, OP_HALT, OP_STEP,
            OP_BP_SET, OP_BP_CLR, OP_CPURST: is_opcode = 1'b1;
            default:                         is_opcode = 1'b0;
        endcase
    endfunction

    // Opcode dispatch from HALTED or RUN; unknown bytes leave the state alone.
    function automatic state_t dispatch(input state_t cur, input logic [7:0] b);
        case (b)
            OP_LOAD:   dispatch = ST_LD_CNT_HI;
            OP_RUN:    dispatch = ST_RUN;
            OP_HALT:   dispatch = ST_HALTED;
            OP_STEP:   dispatch = (cur == ST_HALTED) ? ST_STEP : ST_HALTED;
            OP_BP_SET: dispatch = ST_BP_HI;
            OP_BP_CLR: dispatch = cur;
            OP_CPURST: dispatch = ST_CPURST;
            default:   dispatch = cur;
        endcase
    endfunction

    assign accept_s    = cmd_valid & cmd_ready_r;
    assign cmd_state_s = (state_r == ST_HALTED) || (state_r == ST_RUN);
    assign cmd_next_s  = accept_s ? dispatch(state_r, cmd_data) : state_r;
    assign bp_match_s  = bp_enable_r & bp_armed_r & (pc == bp_addr_r);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_CPURST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; operand states only ever advance on an accepted byte.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_CPURST: next_state_s = ST_HALTED;
            ST_HALTED: next_state_s = cmd_next_s;
            ST_RUN: begin
                if (bp_match_s && (cmd_next_s == ST_RUN)) begin
                    next_state_s = ST_HALTED;
                end else begin
                    next_state_s = cmd_next_s;
                end
            end
            ST_STEP:      next_state_s = ST_HALTED;
            ST_LD_CNT_HI: next_state_s = accept_s ? ST_LD_CNT_LO : ST_LD_CNT_HI;
            ST_LD_CNT_LO: begin
                if (accept_s) begin
                    next_state_s = ({byte_hi_r, cmd_data} == 16'd0) ? ST_CPURST : ST_LD_HI;
                end else begin
                    next_state_s = ST_LD_CNT_LO;
                end
            end
            ST_LD_HI: next_state_s = accept_s ? ST_LD_LO : ST_LD_HI;
            ST_LD_LO: begin
                if (accept_s) begin
                    next_state_s = (words_left_r == 16'd1) ? ST_CPURST : ST_LD_HI;
                end else begin
                    next_state_s = ST_LD_LO;
                end
            end
            ST_BP_HI: next_state_s = accept_s ? ST_BP_LO : ST_BP_HI;
            ST_BP_LO: next_state_s = accept_s ? ST_HALTED : ST_BP_LO;
            default:  next_state_s = ST_CPURST;
        endcase
    end

    // Combinational outputs: the hold must react in the same cycle pc hits the breakpoint.
    always_comb begin
        cpu_hold = 1'b1;
        running  = 1'b0;
        case (state_r)
            ST_RUN: begin
                running  = 1'b1;
                cpu_hold = bp_match_s;
            end
            ST_STEP: begin
                running  = 1'b0;
                cpu_hold = 1'b0;
            end
            default: begin
                running  = 1'b0;
                cpu_hold = 1'b1;
            end
        endcase
    end

    // Operand capture, load counters and breakpoint registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_hi_r    <= 8'h00;
            words_left_r <= 16'd0;
            ld_addr_r    <= '0;
            bp_addr_r    <= '0;
            bp_enable_r  <= 1'b0;
        end else if (accept_s) begin
            case (state_r)
                ST_LD_CNT_HI, ST_LD_HI, ST_BP_HI: byte_hi_r <= cmd_data;
                ST_LD_CNT_LO: words_left_r <= {byte_hi_r, cmd_data};
                ST_LD_LO: begin
                    words_left_r <= words_left_r - 16'd1;
                    ld_addr_r    <= ld_addr_r + ADDR_WIDTH'(1);
                end
                ST_BP_LO: begin
                    bp_addr_r   <= {byte_hi_r[HI_W-1:0], cmd_data};
                    bp_enable_r <= 1'b1;
                end
                ST_HALTED, ST_RUN: begin
                    if (cmd_data == OP_LOAD) begin
                        ld_addr_r <= '0;
                    end
                    if (cmd_data == OP_BP_CLR) begin
                        bp_enable_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Breakpoint is disarmed for the first RUN cycle so a run from bp_addr makes progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bp_armed_r <= 1'b0;
        end else if ((state_r != ST_RUN) && (next_state_s == ST_RUN)) begin
            bp_armed_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            bp_armed_r <= 1'b1;
        end
    end

    // Registered outputs, derived from the upcoming state and the accepted byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_r   <= 1'b0;
            cpu_reset_r   <= 1'b1;
            rom_write_r   <= 1'b0;
            rom_address_r <= '0;
            rom_data_r    <= 16'h0000;
            cmd_error_r   <= 1'b0;
        end else begin
            cmd_ready_r <= (next_state_s != ST_CPURST) && (next_state_s != ST_STEP);
            cpu_reset_r <= (next_state_s == ST_CPURST);
            cmd_error_r <= accept_s && cmd_state_s && !is_opcode(cmd_data);
            rom_write_r <= accept_s && (state_r == ST_LD_LO);
            if (accept_s && (state_r == ST_LD_LO)) begin
                rom_address_r <= ld_addr_r;
                rom_data_r    <= {byte_hi_r, cmd_data};
            end
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign cpu_reset   = cpu_reset_r;
    assign rom_write   = rom_write_r;
    assign rom_address = rom_address_r;
    assign rom_data    = rom_data_r;
    assign cmd_error   = cmd_error_r;

endmodule

// File: tb/tb_hack_run_controller.sv
// Bench for hack_run_controller: directed scenarios plus a randomized command stream
// checked against a transaction-level model (mode, breakpoint, expected ROM image).
module tb_hack_run_controller;

    localparam int AW = 15;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic [7:0]    cmd_data;
    logic          cmd_ready;
    logic [AW-1:0] pc;
    logic          cpu_hold;
    logic          cpu_reset;
    logic          rom_write;
    logic [AW-1:0] rom_address;
    logic [15:0]   rom_data;
    logic          running;
    logic          cmd_error;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    int exp_wr = 0;
    logic [15:0] cap_mem [int];
    logic [15:0] exp_mem [int];
    bit run_m;

    always #5 clock = ~clock;

    hack_run_controller #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .pc(pc), .cpu_hold(cpu_hold), .cpu_reset(cpu_reset),
        .rom_write(rom_write), .rom_address(rom_address), .rom_data(rom_data),
        .running(running), .cmd_error(cmd_error)
    );

    // CPU stand-in: PC advances whenever it is not held.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)       pc <= '0;
        else if (cpu_reset) pc <= '0;
        else if (!cpu_hold) pc <= pc + 15'd1;
    end

    // ROM stand-in capturing every write pulse.
    always @(negedge clock) begin
        if (reset_n && rom_write) begin
            cap_mem[int'(rom_address)] = rom_data;
            wr_count++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: byte %h, cmd_ready stayed %b, required 1", b, cmd_ready);
        end else begin
            cmd_valid = 1'b1;
            cmd_data  = b;
            @(posedge clock);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
        repeat (3) @(negedge clock);
        vectors++;
        if ({cpu_reset, cpu_hold, rom_write, cmd_error, cmd_ready, running} !== 6'b110000 ||
            rom_address !== 15'd0 || rom_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_values: rst/hold/wr/err/rdy/run=%b addr=%h data=%h, required 110000 0 0",
                     {cpu_reset, cpu_hold, rom_write, cmd_error, cmd_ready, running}, rom_address, rom_data);
        end
        reset_n = 1'b1;
        #1;
        vectors++;
        if (cpu_reset !== 1'b1 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cpurst_cycle: cpu_reset=%b cmd_ready=%b, required 1 0", cpu_reset, cmd_ready);
        end
        @(posedge clock); #1;
        vectors++;
        if ({cpu_reset, cpu_hold, running, cmd_ready} !== 4'b0101) begin
            miscompares++;
            $display("FAIL reset_halted: rst/hold/run/rdy=%b, required 0101", {cpu_reset, cpu_hold, running, cmd_ready});
        end
    endtask

    task automatic test_load();
        int wc0;
        wc0 = wr_count;
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        send_byte(8'h34);
        vectors++;
        if (rom_write !== 1'b1 || rom_address !== 15'd0 || rom_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL load_word0: wr=%b addr=%h data=%h, required 1 0000 1234", rom_write, rom_address, rom_data);
        end
        send_byte(8'hAB); send_byte(8'hCD);
        vectors++;
        if (rom_write !== 1'b1 || rom_address !== 15'd1 || rom_data !== 16'hABCD || cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL load_word1: wr=%b addr=%h data=%h rst=%b, required 1 0001 abcd 1",
                     rom_write, rom_address, rom_data, cpu_reset);
        end
        exp_mem[0] = 16'h1234; exp_mem[1] = 16'hABCD; exp_wr += 2;
        @(posedge clock); #1;
        vectors++;
        if ({rom_write, cpu_reset, cmd_ready, cpu_hold, running} !== 5'b00110) begin
            miscompares++;
            $display("FAIL load_end: wr/rst/rdy/hold/run=%b, required 00110",
                     {rom_write, cpu_reset, cmd_ready, cpu_hold, running});
        end
        @(negedge clock);
        vectors++;
        if (wr_count - wc0 !== 2) begin
            miscompares++;
            $display("FAIL load_count: %0d writes, required 2", wr_count - wc0);
        end
    endtask

    task automatic test_breakpoint();
        bit found;
        found = 1'b0;
        send_byte(8'h42); send_byte(8'h00); send_byte(8'h05);
        vectors++;
        if (running !== 1'b0 || cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_set_halted: run=%b hold=%b, required 0 1", running, cpu_hold);
        end
        send_byte(8'h52);
        for (int i = 0; i < 40; i++) begin
            if (pc == 15'd5) begin
                found = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        vectors++;
        if (!found || cpu_hold !== 1'b1 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hit: reached=%b hold=%b run=%b pc=%0d, required 1 1 1 5", found, cpu_hold, running, pc);
        end
        @(posedge clock); #1;
        vectors++;
        if (running !== 1'b0 || pc !== 15'd5) begin
            miscompares++;
            $display("FAIL bp_halted: run=%b pc=%0d, required 0 5", running, pc);
        end
        send_byte(8'h52);
        vectors++;
        if (cpu_hold !== 1'b0 || pc !== 15'd5) begin
            miscompares++;
            $display("FAIL bp_resume: hold=%b pc=%0d, required 0 5", cpu_hold, pc);
        end
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (running !== 1'b1 || pc !== 15'd7) begin
            miscompares++;
            $display("FAIL bp_no_rehalt: run=%b pc=%0d, required 1 7", running, pc);
        end
        send_byte(8'h43);
        send_byte(8'h48);
    endtask

    task automatic test_step();
        logic [AW-1:0] p;
        p = pc;
        send_byte(8'h53);
        vectors++;
        if (cpu_hold !== 1'b0 || cmd_ready !== 1'b0 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL step_cycle: hold=%b rdy=%b run=%b, required 0 0 0", cpu_hold, cmd_ready, running);
        end
        @(posedge clock); #1;
        vectors++;
        if (cpu_hold !== 1'b1 || cmd_ready !== 1'b1 || pc !== p + 15'd1) begin
            miscompares++;
            $display("FAIL step_after: hold=%b rdy=%b pc=%0d, required 1 1 %0d", cpu_hold, cmd_ready, pc, p + 15'd1);
        end
    endtask

    task automatic test_halt_error();
        send_byte(8'h52);
        vectors++;
        if (running !== 1'b1 || cpu_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL run_start: run=%b hold=%b, required 1 0", running, cpu_hold);
        end
        send_byte(8'h7F);
        vectors++;
        if (cmd_error !== 1'b1 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL error_pulse: err=%b run=%b, required 1 1", cmd_error, running);
        end
        @(posedge clock); #1;
        vectors++;
        if (cmd_error !== 1'b0 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL error_single: err=%b run=%b, required 0 1", cmd_error, running);
        end
        send_byte(8'h48);
        vectors++;
        if (cpu_hold !== 1'b1 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL halt: hold=%b run=%b, required 1 0", cpu_hold, running);
        end
    endtask

    task automatic test_load_zero();
        int wc0;
        wc0 = wr_count;
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
        vectors++;
        if (cpu_reset !== 1'b1 || rom_write !== 1'b0) begin
            miscompares++;
            $display("FAIL load_zero_rst: rst=%b wr=%b, required 1 0", cpu_reset, rom_write);
        end
        @(posedge clock); #1;
        vectors++;
        if (cpu_reset !== 1'b0 || cmd_ready !== 1'b1 || wr_count !== wc0) begin
            miscompares++;
            $display("FAIL load_zero_end: rst=%b rdy=%b writes=%0d, required 0 1 0", cpu_reset, cmd_ready, wr_count - wc0);
        end
    endtask

    task automatic test_reset_midload();
        int wc0;
        wc0 = wr_count;
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        exp_mem[0] = 16'h1122; exp_wr += 1;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (rom_write !== 1'b0 || cpu_reset !== 1'b1 || cmd_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL midload_reset: wr=%b rst=%b rdy=%b hold=%b, required 0 1 0 1",
                     rom_write, cpu_reset, cmd_ready, cpu_hold);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        vectors++;
        if (cpu_reset !== 1'b1 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_cpurst: rst=%b rdy=%b, required 1 0", cpu_reset, cmd_ready);
        end
        @(posedge clock); #1;
        vectors++;
        if ({cpu_reset, cmd_ready, cpu_hold, running} !== 4'b0110) begin
            miscompares++;
            $display("FAIL midload_halted: rst/rdy/hold/run=%b, required 0110", {cpu_reset, cmd_ready, cpu_hold, running});
        end
        repeat (6) @(negedge clock);
        vectors++;
        if (wr_count - wc0 !== 1) begin
            miscompares++;
            $display("FAIL midload_writes: %0d writes, required 1", wr_count - wc0);
        end
    endtask

    task automatic test_random();
        int op;
        int n;
        logic [7:0] b;
        logic [15:0] w;
        logic [AW-1:0] p;
        run_m = 1'b0;
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 7));
            case (op)
                0: begin
                    send_byte(8'h52); run_m = 1'b1;
                    vectors++;
                    if (running !== 1'b1 || cpu_hold !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_run: run=%b hold=%b, required 1 0", running, cpu_hold);
                    end
                end
                1: begin
                    send_byte(8'h48); run_m = 1'b0;
                    vectors++;
                    if (running !== 1'b0 || cpu_hold !== 1'b1) begin
                        miscompares++;
                        $display("FAIL rnd_halt: run=%b hold=%b, required 0 1", running, cpu_hold);
                    end
                end
                2: begin
                    p = pc;
                    send_byte(8'h53);
                    vectors++;
                    if (!run_m && (cpu_hold !== 1'b0 || cmd_ready !== 1'b0)) begin
                        miscompares++;
                        $display("FAIL rnd_step: hold=%b rdy=%b, required 0 0", cpu_hold, cmd_ready);
                    end else if (run_m && running !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_step_as_halt: run=%b, required 0", running);
                    end
                    if (!run_m) begin
                        @(posedge clock); #1;
                        vectors++;
                        if (pc !== p + 15'd1 || cpu_hold !== 1'b1) begin
                            miscompares++;
                            $display("FAIL rnd_step_pc: pc=%0d hold=%b, required %0d 1", pc, cpu_hold, p + 15'd1);
                        end
                    end
                    run_m = 1'b0;
                end
                3: begin
                    w = {1'($urandom_range(0, 1)), 1'b1, 14'($urandom_range(0, 16383))};
                    send_byte(8'h42); send_byte(w[15:8]); send_byte(w[7:0]);
                    run_m = 1'b0;
                    vectors++;
                    if (running !== 1'b0 || cpu_hold !== 1'b1) begin
                        miscompares++;
                        $display("FAIL rnd_bpset: run=%b hold=%b, required 0 1", running, cpu_hold);
                    end
                end
                4: begin
                    send_byte(8'h43);
                    vectors++;
                    if (running !== run_m) begin
                        miscompares++;
                        $display("FAIL rnd_bpclr: run=%b, required %b", running, run_m);
                    end
                end
                5: begin
                    b = 8'($urandom_range(0, 255));
                    while (b == 8'h4C || b == 8'h52 || b == 8'h48 || b == 8'h53 ||
                           b == 8'h42 || b == 8'h43 || b == 8'h5A)
                        b = b + 8'd1;
                    send_byte(b);
                    vectors++;
                    if (cmd_error !== 1'b1 || running !== run_m) begin
                        miscompares++;
                        $display("FAIL rnd_unknown: byte=%h err=%b run=%b, required 1 %b", b, cmd_error, running, run_m);
                    end
                end
                6: begin
                    send_byte(8'h5A); run_m = 1'b0;
                    vectors++;
                    if (cpu_reset !== 1'b1 || running !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_cpurst: rst=%b run=%b, required 1 0", cpu_reset, running);
                    end
                    @(posedge clock); #1;
                    vectors++;
                    if (pc !== 15'd0 || cpu_reset !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_cpurst_pc: pc=%0d rst=%b, required 0 0", pc, cpu_reset);
                    end
                end
                default: begin
                    n = int'($urandom_range(0, 3));
                    send_byte(8'h4C); send_byte(8'h00); send_byte(8'(n));
                    for (int k = 0; k < n; k++) begin
                        w = 16'($urandom_range(0, 65535));
                        send_byte(w[15:8]); send_byte(w[7:0]);
                        exp_mem[k] = w; exp_wr++;
                    end
                    run_m = 1'b0;
                    vectors++;
                    if (cpu_reset !== 1'b1 || running !== 1'b0 || rom_write !== (n != 0)) begin
                        miscompares++;
                        $display("FAIL rnd_load_end: n=%0d rst=%b run=%b wr=%b, required 1 0 %b",
                                 n, cpu_reset, running, rom_write, n != 0);
                    end
                end
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        send_byte(8'h48);
        repeat (3) @(negedge clock);
        foreach (exp_mem[a]) begin
            vectors++;
            if (!cap_mem.exists(a) || cap_mem[a] !== exp_mem[a]) begin
                miscompares++;
                $display("FAIL rom_image[%0d]: got %h, required %h", a, cap_mem.exists(a) ? cap_mem[a] : 16'hxxxx, exp_mem[a]);
            end
        end
        vectors++;
        if (wr_count !== exp_wr) begin
            miscompares++;
            $display("FAIL rom_write_total: %0d writes, required %0d", wr_count, exp_wr);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_breakpoint();
        test_step();
        test_halt_error();
        test_load_zero();
        test_reset_midload();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hack_run_controller.md
HACK_RUN_CONTROLLER -- requirements
Module: hack_run_controller

Interface
REQ-001 ADDR_WIDTH, 15: width of the ROM address and PC compare.
REQ-002 clock  in  1  system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command byte available.
REQ-005 cmd_data  in  8  command or operand byte.
REQ-006 cmd_ready  out  1  controller accepts byte; transfer occurs when cmd_valid & cmd_ready are both high at a rising edge.
REQ-007 pc  in  ADDR_WIDTH  current CPU program counter.
REQ-008 cpu_hold  out  1  freezes the CPU; high = no register, PC or memory update.
REQ-009 cpu_reset  out  1  synchronous CPU reset request (PC to 0).
REQ-010 rom_write  out  1  one-cycle instruction-ROM write strobe.
REQ-011 rom_address  out  ADDR_WIDTH  ROM write address.
REQ-012 rom_data  out  16  ROM write data.
REQ-013 running  out  1  high while in RUN.
REQ-014 cmd_error  out  1  one-cycle pulse on an unknown opcode byte.

Function
REQ-015 States: CPURST, HALTED, RUN, STEP, LD_CNT_HI, LD_CNT_LO, LD_HI, LD_LO, BP_HI, BP_LO.
REQ-016 Opcodes, accepted only in HALTED or RUN: 0x4C load; 0x52 run; 0x48 halt; 0x53 step; 0x42 set breakpoint; 0x43 clear breakpoint; 0x5A CPU reset.
REQ-017 cmd_ready = 1 in every state except CPURST and STEP.
REQ-018 cpu_hold = 0 only in STEP, and in RUN when the breakpoint does not match; it is 1 in every other state.
REQ-019 Breakpoint match = bp_enable & bp_armed & (pc == bp_addr); cpu_hold is combinational from the state and this match, so the instruction at bp_addr is never executed.
REQ-020 On a match in RUN, the next state is HALTED.
REQ-021 bp_armed clears on entry to RUN and sets after the first RUN cycle, so that a run started from bp_addr executes that instruction.
REQ-022 0x52 in HALTED: next state RUN. In RUN it is a no-op.
REQ-023 0x48 in RUN: next state HALTED, so cpu_hold is high from the following cycle. In HALTED it is a no-op.
REQ-024 0x53 in HALTED: STEP for exactly one cycle (cpu_hold = 0 regardless of breakpoint), then HALTED. In RUN it acts as 0x48.
REQ-025 0x42: the next two bytes (BP_HI, BP_LO) form bp_addr, high byte first, truncated to ADDR_WIDTH; bp_enable sets after BP_LO.
REQ-026 After a 0x42 sequence the controller returns to HALTED, and cpu_hold stays high throughout.
REQ-027 0x43 clears bp_enable and does not change the state.
REQ-028 0x5A: enter CPURST, in which cpu_reset = 1 and cpu_hold = 1 for exactly one cycle, then go to HALTED.
REQ-029 0x4C: the next two bytes are word count N (big-endian, 16-bit); then 2N data bytes follow, each word sent high byte first.
REQ-030 Load addresses start at 0 and increment after each word, modulo 2^ADDR_WIDTH.
REQ-031 The cycle after the LD_LO byte is accepted: rom_write = 1 with rom_data = {hi, lo} and rom_address = the word index. rom_write is a single-cycle pulse and rom_data/rom_address stay stable during the pulse.
REQ-032 N = 0: go from LD_CNT_LO directly to CPURST with no write.
REQ-033 After the final word: go to CPURST, then HALTED.
REQ-034 Load leaves bp_addr and bp_enable unchanged.
REQ-035 Unknown opcode in HALTED or RUN: cmd_error pulses one cycle and the state is unchanged.
REQ-036 Operand bytes are never decoded as opcodes.
REQ-037 No timeout: an incomplete load or breakpoint sequence waits indefinitely with cpu_hold = 1.
REQ-038 running = (state == RUN).
REQ-039 Outputs other than cpu_hold and running are registered.

Reset
REQ-040 While reset_n = 0, and asynchronously on assertion: state = CPURST, cpu_reset = 1, cpu_hold = 1, rom_write = 0, cmd_error = 0, bp_enable = 0, bp_armed = 0, rom_address = 0, rom_data = 0, cmd_ready = 0.
REQ-041 After reset_n rises: one CPURST cycle, then HALTED.
REQ-042 Reset asserted mid-load aborts the load; words already written stay written and no further rom_write is issued.

Verification
REQ-043 Reset release -> one cycle with cpu_reset = 1, then HALTED: cpu_hold = 1, running = 0, cmd_ready = 1.
REQ-044 Bytes 4C 00 02 12 34 AB CD -> exactly two rom_write pulses (addr 0 data 0x1234, addr 1 data 0xABCD), then one cpu_reset cycle, then HALTED.
REQ-045 Bytes 42 00 05, then 52, with pc stepping 0..5 -> cpu_hold = 1 in the same cycle pc = 5, state HALTED next cycle; a second 52 executes pc = 5 once (no immediate re-halt).
REQ-046 In HALTED, byte 53 -> cpu_hold low for exactly one cycle and cmd_ready low in that cycle, then cpu_hold = 1.
REQ-047 Byte 52, then 48 while running -> cpu_hold = 1 from the cycle after acceptance; byte 0x7F -> one cmd_error pulse with state unchanged.
REQ-048 4C 00 00 -> no rom_write, one cpu_reset cycle; separately, reset_n pulsed low after the first word of a 3-word load -> no further writes and the CPURST then HALTED sequence.
